serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Bit-serial N-bit adder built around the one-bit HalfAdder cell (A,B -> C,S).
//  Accepts two parallel operands over a valid/ready handshake and adds them LSB-first, one bit per clock.
//  A registered carry links the bits. Returns the parallel sum and carry-out over a second valid/ready handshake.
//  Sits directly downstream of operand producers and consumes the bit-level HalfAdder stage.
// PARAMETERS
//  WIDTH   8   operand/sum width in bits; legal range 2..32
// PORTS
//  clk        in   1      system clock; all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand pair a/b (and sub) valid
//  in_ready   out  1      block can accept operands (IDLE only)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  sub        in   1      subtract select (port exists only with SERIAL_ADDER_SUB_EN)
//  out_valid  out  1      sum/cout valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  result, registered
//  cout       out  1      final carry out of MSB, registered
//  busy       out  1      high in SHIFT or DONE
// BEHAVIOUR
//  Single clock; reset is synchronous and active-high.
//  Reset values: in_ready=1, out_valid=0, sum=0, cout=0, busy=0, state=IDLE, carry=0, bit counter=0.
//  FSM states: IDLE, SHIFT, DONE.
//  IDLE: in_ready=1. On in_valid&&in_ready, latch a->shift_a, b->shift_b, carry<=0, cnt<=0, and go to SHIFT.
//  SHIFT: each cycle, bit i = full-add(shift_a[0], shift_b[0], carry).
//   Full add = two half adders: (s1,c1)=HA(a,b); (s,c2)=HA(s1,carry); carry<=c1|c2.
//   Shift shift_a/shift_b right by 1. Shift s into the MSB of the sum shift register. cnt<=cnt+1.
//   When cnt==WIDTH-1, move to DONE.
//  DONE: out_valid=1, with sum and cout=carry stable. Stay until out_ready. On out_valid&&out_ready go to IDLE.
//  Latency: accept edge -> out_valid high exactly WIDTH+1 cycles later (WIDTH shift cycles + 1 register).
//  No new operand is accepted in SHIFT or DONE. in_valid is ignored there, and a/b may change freely.
//  Back-to-back: out handshake returns to IDLE; the next accept happens no earlier than the following cycle.
//  Arithmetic: {cout,sum} == a + b, modulo 2^(WIDTH+1); cout is the unsigned overflow.
//  cnt width = $clog2(WIDTH). cnt wraps to 0 on each accept and never counts past WIDTH-1.
//  Reset mid-operation (SHIFT or DONE): the operation is aborted and no result is emitted. All outputs return to reset values on the next edge.
//  out_ready asserted while out_valid=0 has no effect.
// CONFIGURATION
//  SERIAL_ADDER_SUB_EN defined:
//   - Port sub is present and is latched at accept.
//   - When sub=1: b is inverted at latch and carry starts at 1, so {cout,sum} = a + ~b + 1.
//   - cout=1 means no borrow (a>=b, unsigned).
//  SERIAL_ADDER_SUB_EN undefined:
//   - Port sub is absent; the block is add only and carry always starts at 0.
// STRUCTURE
//  Package serial_adder_pkg:
//   - state typedef enum {IDLE, SHIFT, DONE} (2-bit encoding)
//   - localparam DEFAULT_WIDTH=8
//  Sub-module full_adder_cell: two HalfAdder instances plus an OR on the carries, purely combinational.
//   It is instantiated once, in the SHIFT datapath.
//  The top holds the FSM, counter, operand/sum shift registers and carry register.
// TESTING (WIDTH=8)
//  T1: a=8'h00, b=8'h00 -> out_valid exactly 9 cycles after accept; sum=8'h00, cout=0.
//  T2: a=8'hFF, b=8'h01 -> sum=8'h00, cout=1. Then a=8'hA5, b=8'h5A back-to-back -> sum=8'hFF, cout=0.
//  T3: out_ready held low 5 cycles in DONE -> out_valid, sum, cout stable. in_ready=0 and in_valid is ignored.
//  T4: rst pulsed at shift cycle 4 of a=8'h3C, b=8'h0F -> next cycle state=IDLE, in_ready=1, out_valid=0, sum=0; no result appears.
//  T5 (SERIAL_ADDER_SUB_EN): a=8'h05, b=8'h07, sub=1 -> sum=8'hFE, cout=0. Then a=8'h07, b=8'h05, sub=1 -> sum=8'h02, cout=1.
//  T6: random a/b, 1000 ops, random out_ready -> {cout,sum} matches a+b (or a-b in sub mode) in the scoreboard.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and default width for the serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: one-bit full adder built from two half adder cells and an OR on the carries.
module half_adder (
    input  logic a,
    input  logic b,
    output logic c,
    output logic s
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s1, c1, c2;

    half_adder u_ha0 (.a(a),  .b(b),   .c(c1), .s(s1));
    half_adder u_ha1 (.a(s1), .b(cin), .c(c2), .s(s));

    assign cout = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder with valid/ready on operands and result.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a + ~b + 1 when sub=1).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] shift_a, shift_b;
    logic [CW-1:0]    cnt;
    logic             carry, s, c, accept, inv;

`ifdef SERIAL_ADDER_SUB_EN
    assign inv = sub;
`else
    assign inv = 1'b0;
`endif

    assign in_ready = state == IDLE;
    assign busy     = state != IDLE;
    assign accept   = in_valid && in_ready;
    assign cout     = carry;

    full_adder_cell u_fa (.a(shift_a[0]), .b(shift_b[0]), .cin(carry), .s(s), .cout(c));

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid ? SHIFT : IDLE;
            SHIFT:   state_nx = cnt == LAST ? DONE : SHIFT;
            DONE:    state_nx = out_valid && out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // out_valid rises one cycle after entering DONE, giving WIDTH+1 cycles of latency
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_a   <= '0;
            shift_b   <= '0;
            sum       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= state == DONE && !(out_valid && out_ready);
            if (accept) begin
                shift_a <= a;
                shift_b <= inv ? ~b : b;
                carry   <= inv;
                cnt     <= '0;
            end else if (state == SHIFT) begin
                shift_a <= shift_a >> 1;
                shift_b <= shift_b >> 1;
                sum     <= {s, sum[WIDTH-1:1]};
                carry   <= c;
                cnt     <= cnt == LAST ? cnt : cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vector table, stall/abort sequences and a random scoreboard run.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, sub, out_valid, out_ready, cout, busy;
    logic [W-1:0] a, b, sum;
    int           tests = 0;
    int           fails = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] es;
        logic         ec;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, latency check, optional stall in DONE, then result handshake
    task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is,
                      input logic [W-1:0] es, input logic ec, input int stall, input bit poke);
        int cyc = 0;
        while (!in_ready && cyc < 50) begin
            tick();
            cyc++;
        end
        check("in_ready_before_accept", 32'(in_ready), 1);
        a = ia; b = ib; sub = is; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            tick();
            cyc++;
            if (poke) begin
                a = ~a; b = ~b; in_valid = cyc[0];
            end
        end
        in_valid = 1'b0;
        check("latency", cyc, W + 1);
        for (int i = 0; i < stall; i++) begin
            if (poke) begin
                in_valid = 1'b1; a = 8'h11; b = 8'h22;
            end
            check("stall_in_ready", 32'(in_ready), 0);
            tick();
            check("stall_out_valid", 32'(out_valid), 1);
            check("stall_busy", 32'(busy), 1);
        end
        in_valid = 1'b0;
        check("sum", 32'(sum), 32'(es));
        check("cout", 32'(cout), 32'(ec));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_after_hs", 32'(out_valid), 0);
        check("in_ready_after_hs", 32'(in_ready), 1);
    endtask

    initial begin
        vec_t vecs[6];
        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
        vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1};
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_sum", 32'(sum), 0);
        check("rst_cout", 32'(cout), 0);
        check("rst_busy", 32'(busy), 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_out_ready_no_effect", 32'(out_valid), 0);
        for (int i = 0; i < 6; i++)
            op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].es, vecs[i].ec, 0, 1'b0);
        // stall in DONE with in_valid and operands wiggling
        op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 5, 1'b1);
        tick();
        check("no_spurious_accept", 32'(busy), 0);
        // abort mid-shift
        a = 8'h3C; b = 8'h0F; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("abort_busy_before", 32'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", 32'(in_ready), 1);
        check("abort_out_valid", 32'(out_valid), 0);
        check("abort_sum", 32'(sum), 0);
        check("abort_cout", 32'(cout), 0);
        check("abort_busy", 32'(busy), 0);
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 15; i++) begin
                tick();
                seen |= out_valid | busy;
            end
            check("abort_no_result", 32'(seen), 0);
        end
`ifdef SERIAL_ADDER_SUB_EN
        op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 0, 1'b0);
        op(8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 0, 1'b0);
`endif
        for (int n = 0; n < 1000; n++) begin
            logic [W-1:0] ra, rb;
            logic         rs;
            logic [W:0]   e;
            ra = W'($urandom);
            rb = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            e = rs ? {1'b0, ra} + {1'b0, ~rb} + 9'd1 : {1'b0, ra} + {1'b0, rb};
            op(ra, rb, rs, e[W-1:0], e[W], int'($urandom_range(0, 3)), 1'b0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
